// File: rtl/data_memory_mp.sv
// data_memory_mp: dual-port word RAM (port A load/store with byte enables, port B read-only), keyboard MMIO word, optional post-reset clear; ports: clk, rst_n, a_* CPU port, b_* display port, kb_* keyboard, busy; define DMEM_FWD_EN for write-first port A
module data_memory_mp #(
  parameter int BUS          = 32,
  parameter int DEPTH        = 4096,
  parameter int MMIO_WORD    = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_re,
  input  logic                     a_we,
  input  logic [BUS/8-1:0]         a_be,
  input  logic [BUS-1:0]           a_addr,
  input  logic [BUS-1:0]           a_wdata,
  output logic [BUS-1:0]           a_rdata,
  output logic                     a_rvalid,
  output logic                     a_err,
  input  logic                     b_re,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  output logic [BUS-1:0]           b_rdata,
  output logic                     b_rvalid,
  input  logic [BUS-1:0]           kb_data,
  input  logic                     kb_strobe,
  output logic                     kb_pending,
  output logic                     busy
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] MMIO_IDX = ADDR_W'(MMIO_WORD);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [BUS-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d, fwd;
  logic a_rvalid_q, a_rvalid_d, a_err_q, a_err_d, b_rvalid_q, b_rvalid_d;
  logic kb_pending_q, kb_pending_d;
  logic run, oor, a_rd, a_wr, kb_wr;
  logic [ADDR_W-1:0] wa;
  logic [BUS-1:0] mem [DEPTH];
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^a_addr[1:0];
  always_comb begin
    run = state_q == RUN;
    wa = a_addr[ADDR_W+1:2];
    oor = |a_addr[BUS-1:ADDR_W+2];
    a_rd = run & a_re;
    a_wr = run & a_we & ~oor;
    kb_wr = run & kb_strobe;
    fwd = mem[wa];
`ifdef DMEM_FWD_EN
    for (int i = 0; i < BUS/8; i++)
      if (a_wr && a_be[i]) fwd[8*i +: 8] = a_wdata[8*i +: 8];
    if (kb_wr && wa == MMIO_IDX) fwd = kb_data;
`else
`endif
    state_d = (state_q == CLEAR && cnt_q == ADDR_W'(DEPTH-1)) ? RUN : state_q;
    cnt_d = run ? cnt_q : cnt_q + 1'b1;
    a_rdata_d = a_rd ? (oor ? '0 : fwd) : a_rdata_q;
    a_rvalid_d = a_rd;
    a_err_d = run & (a_re | a_we) & oor;
    b_rdata_d = (run & b_re) ? mem[b_addr] : b_rdata_q;
    b_rvalid_d = run & b_re;
    // a same-cycle strobe takes priority over the clearing read
    kb_pending_d = kb_wr | (kb_pending_q & ~(a_rd & ~oor & wa == MMIO_IDX));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
      cnt_q <= '0;
      a_rdata_q <= '0;
      a_rvalid_q <= 1'b0;
      a_err_q <= 1'b0;
      b_rdata_q <= '0;
      b_rvalid_q <= 1'b0;
      kb_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_rdata_q <= a_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      a_err_q <= a_err_d;
      b_rdata_q <= b_rdata_d;
      b_rvalid_q <= b_rvalid_d;
      kb_pending_q <= kb_pending_d;
    end
  end
  // keyboard write is last so it overrides a port A write to the MMIO word
  always_ff @(posedge clk) begin
    if (!run) mem[cnt_q] <= '0;
    else begin
      for (int i = 0; i < BUS/8; i++)
        if (a_wr && a_be[i]) mem[wa][8*i +: 8] <= a_wdata[8*i +: 8];
      if (kb_wr) mem[MMIO_IDX] <= kb_data;
    end
  end
  assign a_rdata = a_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign a_err = a_err_q;
  assign b_rdata = b_rdata_q;
  assign b_rvalid = b_rvalid_q;
  assign kb_pending = kb_pending_q;
  assign busy = state_q == CLEAR;
endmodule
